// File: rtl/ddr4_cmd_bank_monitor_if.sv
// DDR4 command/address bus bundle observed by ddr4_cmd_bank_monitor.
// The master modport drives the bus (memory controller or bench driver);
// the slave modport only samples it (the passive monitor).
interface ddr4_ca_if #(
  parameter int RANK_BITS = 1,
  parameter int BG_BITS   = 2,
  parameter int BA_BITS   = 2
);
  logic                 CS_n;
  logic                 ACT_n;
  logic                 RAS_n_A16;
  logic                 CAS_n_A15;
  logic                 WE_n_A14;
  logic [RANK_BITS-1:0] C;
  logic [BG_BITS-1:0]   BG;
  logic [BA_BITS-1:0]   BA;
  logic [13:0]          ADDR;
  logic                 ADDR_17;
  logic                 PARITY;

  modport master (
    output CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
    output C, BG, BA, ADDR, ADDR_17, PARITY
  );

  modport slave (
    input CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
    input C, BG, BA, ADDR, ADDR_17, PARITY
  );
endinterface

// File: rtl/ddr4_cmd_bank_monitor.sv
// Passive DDR4 command/bank monitor.
// Decodes every command on the CA bus (one cycle registered latency),
// tracks a per-bank IDLE/OPEN state with tRCD/tRAS/tRP elapsed-cycle
// counters, and records protocol violations in a sticky error vector
// with a saturating violation counter.
// Optional build macro: DDR4_CA_PARITY_CHK_EN enables the CA parity check
// (err_vec[6]); without it PARITY is ignored and err_vec[6] stays 0.
module ddr4_cmd_bank_monitor #(
  parameter int RANK_BITS = 1,
  parameter int BG_BITS   = 2,
  parameter int BA_BITS   = 2,
  parameter int T_RCD     = 14,
  parameter int T_RAS     = 32,
  parameter int T_RP      = 14,
  parameter int CNT_W     = 8
) (
  input  logic                                     CK_t,
  input  logic                                     RST,
  ddr4_ca_if.slave                                 ca,
  input  logic                                     err_clr,
  output logic                                     cmd_valid,
  output logic [2:0]                               cmd_code,
  output logic [RANK_BITS+BG_BITS+BA_BITS-1:0]     cmd_bank,
  output logic [17:0]                              cmd_addr,
  output logic [2**(RANK_BITS+BG_BITS+BA_BITS)-1:0] bank_open,
  output logic [6:0]                               err_vec,
  output logic [15:0]                              err_count
);

  localparam int BANK_W    = RANK_BITS + BG_BITS + BA_BITS;
  localparam int NUM_BANKS = 2 ** BANK_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_ACT   = 3'd1,
    CMD_RD    = 3'd2,
    CMD_WR    = 3'd3,
    CMD_PRE   = 3'd4,
    CMD_PREA  = 3'd5,
    CMD_REF   = 3'd6,
    CMD_OTHER = 3'd7
  } cmd_e;

  typedef enum logic {
    BANK_IDLE = 1'b0,
    BANK_OPEN = 1'b1
  } bank_state_e;

  // Counter increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // True when fewer than tmin cycles have elapsed since the event.
  // The counter is cleared on the event edge, so elapsed = cnt + 1.
  function automatic logic too_soon(input logic [CNT_W-1:0] cnt, input int tmin);
    logic [CNT_W:0] elapsed;
    elapsed = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    return elapsed < (CNT_W+1)'(tmin);
  endfunction

  // Rank field of a flat {C,BG,BA} bank number.
  function automatic logic [RANK_BITS-1:0] rank_of(input int b);
    logic [BANK_W-1:0] bv;
    bv = BANK_W'(b);
    return bv[BANK_W-1 -: RANK_BITS];
  endfunction

  // Number of error bits raised in one cycle.
  function automatic logic [2:0] err_pop(input logic [6:0] e);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 7; i++) begin
      n = n + {2'b00, e[i]};
    end
    return n;
  endfunction

  // Even CA parity: XOR over all covered pins including PARITY must be 0.
  function automatic logic ca_parity_bad(
    input logic                 par,
    input logic                 act_n,
    input logic                 ras,
    input logic                 cas,
    input logic                 we,
    input logic [BG_BITS-1:0]   bg,
    input logic [BA_BITS-1:0]   ba,
    input logic [13:0]          addr,
    input logic                 a17,
    input logic [RANK_BITS-1:0] c
  );
    return ^{par, act_n, ras, cas, we, bg, ba, addr, a17, c};
  endfunction

  // Decode
  cmd_e              dec_code_s;
  logic              dec_valid_s;
  logic [17:0]       dec_addr_s;
  logic [BANK_W-1:0] dec_bank_s;
  logic              parity_err_s;

  // Registered outputs
  logic              cmd_valid_q, cmd_valid_d;
  logic [2:0]        cmd_code_q,  cmd_code_d;
  logic [BANK_W-1:0] cmd_bank_q,  cmd_bank_d;
  logic [17:0]       cmd_addr_q,  cmd_addr_d;
  logic [6:0]        err_vec_q,   err_vec_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [6:0]        err_new_s;
  logic [16:0]       err_sum_s;

  // Per-bank tracking
  bank_state_e       bank_state_q [NUM_BANKS];
  bank_state_e       bank_state_d [NUM_BANKS];
  logic [CNT_W-1:0]  act_cnt_q    [NUM_BANKS];
  logic [CNT_W-1:0]  act_cnt_d    [NUM_BANKS];
  logic [CNT_W-1:0]  pre_cnt_q    [NUM_BANKS];
  logic [CNT_W-1:0]  pre_cnt_d    [NUM_BANKS];

`ifdef DDR4_CA_PARITY_CHK_EN
  assign parity_err_s = ~ca.CS_n & ca_parity_bad(ca.PARITY, ca.ACT_n, ca.RAS_n_A16,
                                                 ca.CAS_n_A15, ca.WE_n_A14, ca.BG,
                                                 ca.BA, ca.ADDR, ca.ADDR_17, ca.C);
`else
  logic unused_parity_s;
  assign unused_parity_s = ca.PARITY;
  assign parity_err_s    = 1'b0;
`endif

  // Command decode of the bus as sampled on this edge.
  always_comb begin
    dec_code_s  = CMD_NOP;
    dec_valid_s = 1'b0;
    dec_addr_s  = 18'd0;
    dec_bank_s  = {ca.C, ca.BG, ca.BA};
    if (!ca.CS_n) begin
      dec_valid_s = 1'b1;
      if (!ca.ACT_n) begin
        dec_code_s = CMD_ACT;
        dec_addr_s = {ca.ADDR_17, ca.RAS_n_A16, ca.CAS_n_A15, ca.WE_n_A14, ca.ADDR};
      end else begin
        case ({ca.RAS_n_A16, ca.CAS_n_A15, ca.WE_n_A14})
          3'b000:  dec_code_s = CMD_OTHER;
          3'b001:  dec_code_s = CMD_REF;
          3'b010:  dec_code_s = ca.ADDR[10] ? CMD_PREA : CMD_PRE;
          3'b101: begin
            dec_code_s = CMD_RD;
            dec_addr_s = {8'd0, ca.ADDR[9:0]};
          end
          3'b100: begin
            dec_code_s = CMD_WR;
            dec_addr_s = {8'd0, ca.ADDR[9:0]};
          end
          3'b111:  dec_code_s = CMD_NOP;
          default: dec_code_s = CMD_OTHER;
        endcase
      end
    end else begin
      dec_bank_s = {BANK_W{1'b0}};
    end
  end

  // Per-bank next state, timing counters and protocol checks.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_state_d[b] = bank_state_q[b];
      act_cnt_d[b]    = sat_inc(act_cnt_q[b]);
      pre_cnt_d[b]    = sat_inc(pre_cnt_q[b]);
    end
    err_new_s    = 7'd0;
    err_new_s[6] = parity_err_s;
    case (dec_code_s)
      CMD_ACT: begin
        if (bank_state_q[dec_bank_s] == BANK_OPEN) begin
          err_new_s[0] = 1'b1;
        end else begin
          err_new_s[4]             = too_soon(pre_cnt_q[dec_bank_s], T_RP);
          bank_state_d[dec_bank_s] = BANK_OPEN;
          act_cnt_d[dec_bank_s]    = {CNT_W{1'b0}};
        end
      end
      CMD_RD, CMD_WR: begin
        if (bank_state_q[dec_bank_s] == BANK_IDLE) begin
          err_new_s[1] = 1'b1;
        end else begin
          err_new_s[2] = too_soon(act_cnt_q[dec_bank_s], T_RCD);
        end
      end
      CMD_PRE: begin
        // Precharging an idle bank is a legal no-op and leaves tRP untouched.
        if (bank_state_q[dec_bank_s] == BANK_OPEN) begin
          err_new_s[3]             = too_soon(act_cnt_q[dec_bank_s], T_RAS);
          bank_state_d[dec_bank_s] = BANK_IDLE;
          pre_cnt_d[dec_bank_s]    = {CNT_W{1'b0}};
        end else begin
          bank_state_d[dec_bank_s] = BANK_IDLE;
        end
      end
      CMD_PREA: begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          if ((rank_of(b) == ca.C) && (bank_state_q[b] == BANK_OPEN)) begin
            err_new_s[3]    = err_new_s[3] | too_soon(act_cnt_q[b], T_RAS);
            bank_state_d[b] = BANK_IDLE;
            pre_cnt_d[b]    = {CNT_W{1'b0}};
          end else begin
            bank_state_d[b] = bank_state_q[b];
          end
        end
      end
      CMD_REF: begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          if ((rank_of(b) == ca.C) && (bank_state_q[b] == BANK_OPEN)) begin
            err_new_s[5] = 1'b1;
          end else begin
            err_new_s[5] = err_new_s[5];
          end
        end
      end
      default: err_new_s[5] = 1'b0;
    endcase
  end

  // Output register next values; a new error beats a simultaneous clear.
  always_comb begin
    cmd_valid_d = dec_valid_s;
    cmd_code_d  = dec_code_s;
    cmd_bank_d  = dec_bank_s;
    cmd_addr_d  = dec_addr_s;
    err_sum_s   = {1'b0, err_count_q} + {14'd0, err_pop(err_new_s)};
    if (err_clr) begin
      err_vec_d   = err_new_s;
      err_count_d = {13'd0, err_pop(err_new_s)};
    end else begin
      err_vec_d   = err_vec_q | err_new_s;
      err_count_d = err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
    end
  end

  // Bank state and timing counter registers; counters reset to max so no
  // timing check fires straight out of reset.
  always_ff @(posedge CK_t) begin
    if (RST) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_state_q[b] <= BANK_IDLE;
        act_cnt_q[b]    <= CNT_MAX;
        pre_cnt_q[b]    <= CNT_MAX;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_state_q[b] <= bank_state_d[b];
        act_cnt_q[b]    <= act_cnt_d[b];
        pre_cnt_q[b]    <= pre_cnt_d[b];
      end
    end
  end

  // Decoded-command stream and sticky error registers.
  always_ff @(posedge CK_t) begin
    if (RST) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 3'd0;
      cmd_bank_q  <= {BANK_W{1'b0}};
      cmd_addr_q  <= 18'd0;
      err_vec_q   <= 7'd0;
      err_count_q <= 16'd0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_addr_q  <= cmd_addr_d;
      err_vec_q   <= err_vec_d;
      err_count_q <= err_count_d;
    end
  end

  // Per-bank open indicator taken straight from the state registers.
  always_comb begin
    bank_open = {NUM_BANKS{1'b0}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_open[b] = (bank_state_q[b] == BANK_OPEN);
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_addr  = cmd_addr_q;
  assign err_vec   = err_vec_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ddr4_cmd_bank_monitor.sv
// Directed bench for ddr4_cmd_bank_monitor with default parameters
// (1 rank bit, 2 BG bits, 2 BA bits, tRCD 14, tRAS 32, tRP 14).
module tb_ddr4_cmd_bank_monitor;

  logic        CK_t = 1'b0;
  logic        RST;
  logic        err_clr;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [4:0]  cmd_bank;
  logic [17:0] cmd_addr;
  logic [31:0] bank_open;
  logic [6:0]  err_vec;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  ddr4_ca_if #(.RANK_BITS(1), .BG_BITS(2), .BA_BITS(2)) ca ();

  ddr4_cmd_bank_monitor dut (
    .CK_t      (CK_t),
    .RST       (RST),
    .ca        (ca.slave),
    .err_clr   (err_clr),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_bank  (cmd_bank),
    .cmd_addr  (cmd_addr),
    .bank_open (bank_open),
    .err_vec   (err_vec),
    .err_count (err_count)
  );

  always #5 CK_t = ~CK_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK_t);
    #1;
  endtask

  task automatic deselect();
    ca.CS_n      = 1'b1;
    ca.ACT_n     = 1'b1;
    ca.RAS_n_A16 = 1'b1;
    ca.CAS_n_A15 = 1'b1;
    ca.WE_n_A14  = 1'b1;
    ca.C         = 1'b0;
    ca.BG        = 2'd0;
    ca.BA        = 2'd0;
    ca.ADDR      = 14'd0;
    ca.ADDR_17   = 1'b0;
    ca.PARITY    = 1'b0;
  endtask

  task automatic idle(input int n);
    deselect();
    repeat (n) tick();
  endtask

  // Drive one command for one edge. For ACT, a is the 18-bit row; otherwise
  // rcw selects {RAS,CAS,WE} and a[13:0] goes on ADDR.
  task automatic send(input logic act_n, input logic [2:0] rcw, input logic [4:0] bank,
                      input logic [17:0] a, input logic bad_par);
    ca.CS_n  = 1'b0;
    ca.ACT_n = act_n;
    if (!act_n) begin
      {ca.ADDR_17, ca.RAS_n_A16, ca.CAS_n_A15, ca.WE_n_A14, ca.ADDR} = a;
    end else begin
      {ca.RAS_n_A16, ca.CAS_n_A15, ca.WE_n_A14} = rcw;
      ca.ADDR    = a[13:0];
      ca.ADDR_17 = 1'b0;
    end
    {ca.C, ca.BG, ca.BA} = bank;
    ca.PARITY = (^{ca.ACT_n, ca.RAS_n_A16, ca.CAS_n_A15, ca.WE_n_A14, ca.BG, ca.BA,
                   ca.ADDR, ca.ADDR_17, ca.C}) ^ bad_par;
    tick();
    deselect();
  endtask

  task automatic do_reset();
    deselect();
    err_clr = 1'b0;
    RST     = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    // Reset and deselected bus
    do_reset();
    check("rst_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_code", {29'd0, cmd_code}, 32'd0);
    check("rst_err", {25'd0, err_vec}, 32'd0);
    check("rst_count", {16'd0, err_count}, 32'd0);
    check("rst_open", bank_open, 32'd0);
    idle(5);
    check("des_valid", {31'd0, cmd_valid}, 32'd0);
    check("des_err", {25'd0, err_vec}, 32'd0);
    check("des_open", bank_open, 32'd0);

    // Legal ACT -> RD -> PRE -> ACT on bank 3 at exact timing limits
    send(1'b0, 3'b000, 5'd3, 18'h01234, 1'b0);
    check("act_valid", {31'd0, cmd_valid}, 32'd1);
    check("act_code", {29'd0, cmd_code}, 32'd1);
    check("act_addr", {14'd0, cmd_addr}, 32'h1234);
    check("act_bank", {27'd0, cmd_bank}, 32'd3);
    check("act_open", bank_open, 32'h8);
    idle(13);
    send(1'b1, 3'b101, 5'd3, 18'h000AB, 1'b0);
    check("rd_code", {29'd0, cmd_code}, 32'd2);
    check("rd_addr", {14'd0, cmd_addr}, 32'h0AB);
    check("rd_err", {25'd0, err_vec}, 32'd0);
    idle(17);
    send(1'b1, 3'b010, 5'd3, 18'h0, 1'b0);
    check("pre_code", {29'd0, cmd_code}, 32'd4);
    check("pre_open", bank_open, 32'd0);
    check("pre_err", {25'd0, err_vec}, 32'd0);
    idle(13);
    send(1'b0, 3'b000, 5'd3, 18'h00055, 1'b0);
    check("act2_code", {29'd0, cmd_code}, 32'd1);
    check("act2_err", {25'd0, err_vec}, 32'd0);
    check("act2_count", {16'd0, err_count}, 32'd0);

    // tRCD violation, then ACT to an already open bank
    do_reset();
    send(1'b0, 3'b000, 5'd0, 18'h00001, 1'b0);
    idle(4);
    send(1'b1, 3'b101, 5'd0, 18'h0, 1'b0);
    check("trcd_err", {25'd0, err_vec}, 32'h04);
    check("trcd_count", {16'd0, err_count}, 32'd1);
    send(1'b0, 3'b000, 5'd0, 18'h00002, 1'b0);
    check("actopen_err", {25'd0, err_vec}, 32'h05);
    check("actopen_count", {16'd0, err_count}, 32'd2);

    // WR one cycle short of tRCD, legal PRE, ACT one cycle short of tRP
    do_reset();
    send(1'b0, 3'b000, 5'd7, 18'h00100, 1'b0);
    idle(12);
    send(1'b1, 3'b100, 5'd7, 18'h00003, 1'b0);
    check("wr_code", {29'd0, cmd_code}, 32'd3);
    check("wr_trcd_err", {25'd0, err_vec}, 32'h04);
    idle(18);
    send(1'b1, 3'b010, 5'd7, 18'h0, 1'b0);
    check("pre7_err", {25'd0, err_vec}, 32'h04);
    check("pre7_count", {16'd0, err_count}, 32'd1);
    idle(12);
    send(1'b0, 3'b000, 5'd7, 18'h00100, 1'b0);
    check("trp_err", {25'd0, err_vec}, 32'h14);
    check("trp_count", {16'd0, err_count}, 32'd2);

    // RD to idle bank, REF with open bank, clear racing a tRAS violation
    do_reset();
    send(1'b1, 3'b101, 5'd5, 18'h0, 1'b0);
    check("rdidle_err", {25'd0, err_vec}, 32'h02);
    check("rdidle_count", {16'd0, err_count}, 32'd1);
    send(1'b0, 3'b000, 5'd2, 18'h00010, 1'b0);
    send(1'b1, 3'b001, 5'd0, 18'h0, 1'b0);
    check("ref_code", {29'd0, cmd_code}, 32'd6);
    check("ref_err", {25'd0, err_vec}, 32'h22);
    check("ref_count", {16'd0, err_count}, 32'd2);
    check("ref_open", bank_open, 32'h4);
    err_clr = 1'b1;
    send(1'b1, 3'b010, 5'd2, 18'h0, 1'b0);
    err_clr = 1'b0;
    check("clr_tras_err", {25'd0, err_vec}, 32'h08);
    check("clr_tras_count", {16'd0, err_count}, 32'd1);
    check("clr_tras_open", bank_open, 32'd0);

    // PREA closes banks 1 and 6 of rank 0
    do_reset();
    send(1'b0, 3'b000, 5'd1, 18'h00020, 1'b0);
    send(1'b0, 3'b000, 5'd6, 18'h00030, 1'b0);
    check("two_open", bank_open, 32'h42);
    idle(38);
    send(1'b1, 3'b010, 5'd0, 18'h00400, 1'b0);
    check("prea_code", {29'd0, cmd_code}, 32'd5);
    check("prea_addr", {14'd0, cmd_addr}, 32'd0);
    check("prea_open", bank_open, 32'd0);
    check("prea_err", {25'd0, err_vec}, 32'd0);

    // Reset inside a tRCD window suppresses the pending violation
    send(1'b0, 3'b000, 5'd1, 18'h00040, 1'b0);
    check("midrst_pre_open", bank_open, 32'h2);
    idle(1);
    RST = 1'b1;
    send(1'b1, 3'b101, 5'd1, 18'h0, 1'b0);
    RST = 1'b0;
    check("midrst_valid", {31'd0, cmd_valid}, 32'd0);
    check("midrst_code", {29'd0, cmd_code}, 32'd0);
    check("midrst_open", bank_open, 32'd0);
    check("midrst_err", {25'd0, err_vec}, 32'd0);
    check("midrst_count", {16'd0, err_count}, 32'd0);
    send(1'b1, 3'b101, 5'd1, 18'h0, 1'b0);
    check("postrst_err", {25'd0, err_vec}, 32'h02);

    // ACT carrying a wrong CA parity bit
    do_reset();
    send(1'b0, 3'b000, 5'd4, 18'h00777, 1'b1);
    check("par_code", {29'd0, cmd_code}, 32'd1);
    check("par_open", bank_open, 32'h10);
`ifdef DDR4_CA_PARITY_CHK_EN
    check("par_err", {25'd0, err_vec}, 32'h40);
    check("par_count", {16'd0, err_count}, 32'd1);
`else
    check("par_err", {25'd0, err_vec}, 32'd0);
    check("par_count", {16'd0, err_count}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr4_cmd_bank_monitor.md
Name: ddr4_cmd_bank_monitor

Overview:
- Passive, parametrised monitor on the DDR4 command/address bus.
- Samples the bus every rising CK_t and decodes each command; decode is generalised over logical-rank (C), bank-group and bank widths.
- Tracks a per-bank state machine with tRCD/tRAS/tRP counters, flags protocol violations in a sticky error vector, and emits a decoded-command stream for scoreboards.
- Sits in the testbench beside the DDR4 memory model; drives nothing onto the DRAM pins.

Parameters:
- RANK_BITS, 1, width of C (logical ranks = 2**RANK_BITS)
- BG_BITS, 2, bank-group address width
- BA_BITS, 2, bank address width
- T_RCD, 14, minimum CK cycles ACT -> RD/WR same bank
- T_RAS, 32, minimum CK cycles ACT -> PRE same bank
- T_RP, 14, minimum CK cycles PRE -> ACT same bank
- CNT_W, 8, timing counter width; must hold max(T_RCD,T_RAS,T_RP)

Ports:
- CK_t  in  1  command clock; all logic on rising edge
- RST  in  1  synchronous active-high reset
- CS_n  in  1  chip select, low = command valid
- ACT_n  in  1  activate strobe
- RAS_n_A16  in  1  RAS / row bit 16
- CAS_n_A15  in  1  CAS / row bit 15
- WE_n_A14  in  1  WE / row bit 14
- C  in  RANK_BITS  logical rank
- BG  in  BG_BITS  bank group
- BA  in  BA_BITS  bank
- ADDR  in  14  address A13..A0
- ADDR_17  in  1  row bit 17
- PARITY  in  1  CA parity
- err_clr  in  1  clears sticky errors and count
- cmd_valid  out  1  decoded command valid this cycle
- cmd_code  out  3  0 NOP/DES, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 MRS/ZQ/other
- cmd_bank  out  RANK_BITS+BG_BITS+BA_BITS  {C,BG,BA}
- cmd_addr  out  18  row for ACT, {8'b0,ADDR[9:0]} for RD/WR, 0 otherwise
- bank_open  out  2**(RANK_BITS+BG_BITS+BA_BITS)  per-bank ACTIVE/ACTIVATING indicator
- err_vec  out  7  sticky: [0] ACT to open bank, [1] RD/WR to closed bank, [2] tRCD, [3] tRAS, [4] tRP, [5] REF with open bank, [6] parity
- err_count  out  16  total violations, saturating at 16'hFFFF

Behaviour:
- Reset (RST=1 on a CK_t edge): all outputs 0; every bank IDLE; all counters at their max value so no timing violation fires after reset.
- Registered decode, latency 1 cycle: a command sampled at edge n appears on cmd_* at edge n+1 with cmd_valid=1. CS_n=1 gives cmd_valid=0.
- Decode:
  - ACT_n=0: ACT, row = {ADDR_17,RAS_n_A16,CAS_n_A15,WE_n_A14,ADDR}.
  - ACT_n=1, {RAS,CAS,WE}: LLL=MRS(7), LLH=REF, LHL=PRE (PREA if ADDR[10]=1), HLH=RD, HLL=WR, HHH=NOP, LHH/HHL=7.
- Per-bank FSM, indexed by {C,BG,BA}:
  - IDLE -ACT-> OPEN (act_cnt cleared).
  - OPEN -PRE/PREA-> IDLE (pre_cnt cleared).
  - act_cnt and pre_cnt increment each cycle, saturating at 2**CNT_W-1.
- Checks (cnt = cycles elapsed since the event):
  - ACT on OPEN bank: err[0]; state unchanged.
  - ACT on IDLE bank with pre_cnt < T_RP: err[4]; ACT still performed.
  - RD/WR on IDLE bank: err[1].
  - RD/WR on OPEN bank with act_cnt < T_RCD: err[2].
  - PRE on OPEN bank with act_cnt < T_RAS: err[3].
  - PRE on IDLE bank: legal no-op; pre_cnt not cleared.
  - PREA applies PRE rules to every bank of rank C at once.
  - REF while any bank of rank C is OPEN: err[5].
- Errors are flagged on the same edge cmd_valid is asserted.
- err_count adds the number of new error bits set in that cycle (a single command can set at most 2).
- err_clr: clears err_vec and err_count. If a new error occurs in the same cycle as err_clr, the new error wins: the bit is set and the count becomes its increment.
- Mid-operation RST returns every bank to IDLE and suppresses any error on that edge.

Optional Feature:
- DDR4_CA_PARITY_CHK_EN defined: parity is checked when CS_n=0. The XOR of PARITY, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14, BG, BA, ADDR, ADDR_17 and C must be 0; a mismatch sets err[6]. The command is still decoded normally.
- Undefined: PARITY is ignored and err[6] is tied to 0.

Test Plan:
- Reset, then NOP for 5 cycles -> cmd_valid=0, err_vec=0, bank_open=0.
- ACT bank 3 row 18'h1234; RD at +14 cycles; PRE at +32; ACT at +14 after PRE -> cmd_code sequence 1,2,4,1; cmd_addr=18'h1234 for the ACT; err_vec=0.
- ACT bank 0, RD at +5 cycles -> err_vec[2]=1, err_count=1. Then ACT bank 0 again -> err_vec[0]=1, err_count=2.
- RD to IDLE bank 5, then REF while bank 2 is open -> err_vec=7'b0100010, err_count=2. err_clr pulsed in the same cycle as a tRAS violation -> err_vec=7'b0001000, err_count=1.
- Open banks 1 and 6 on rank 0; PREA (ADDR[10]=1) at +40 cycles -> bank_open bits 1 and 6 clear the next cycle, no error. RST asserted mid-tRCD window -> all outputs 0.
- With DDR4_CA_PARITY_CHK_EN: send ACT with a wrong PARITY -> err_vec[6]=1 and cmd_code=1. Without the macro, same stimulus -> err_vec[6]=0.
